branch_target_buffer: RTL and testbench

//   Parametrised successor to the single-entry branch predictor: direct-mapped BTB with per-entry
//   2-bit saturating direction counters, plus EXE-stage mispredict detection and pipeline flush generation.

---
 rtl/branch_target_buffer.sv | 143 ++++++++++++++
 tb/tb_branch_target_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters, EXE-stage
// mispredict/redirect generation and saturating debug statistics counters.
module branch_target_buffer #(
  parameter int         INDEX_BITS = 4,
  parameter int         TAG_BITS   = 8,
  parameter logic [1:0] CTR_INIT   = 2'b01,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [31:0]      rd_pc,
  output logic             hit,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] lookup_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic                  valid_r  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_r    [ENTRIES];
  logic [31:0]           target_r [ENTRIES];
  logic [1:0]            ctr_r    [ENTRIES];

  logic [INDEX_BITS-1:0] rd_idx_s;
  logic [INDEX_BITS-1:0] upd_idx_s;
  logic [TAG_BITS-1:0]   rd_tag_s;
  logic [TAG_BITS-1:0]   upd_tag_s;
  logic                  upd_hit_s;
  logic                  unused_s;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    if (c == 2'b11) return c;
    else return c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    if (c == 2'b00) return c;
    else return c - 2'b01;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    else return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign rd_idx_s  = rd_pc[INDEX_BITS+1:2];
  assign rd_tag_s  = rd_pc[INDEX_BITS+2 +: TAG_BITS];
  assign upd_idx_s = upd_pc[INDEX_BITS+1:2];
  assign upd_tag_s = upd_pc[INDEX_BITS+2 +: TAG_BITS];
  assign upd_hit_s = valid_r[upd_idx_s] & (tag_r[upd_idx_s] == upd_tag_s);
  // Only index and tag fields of the PCs select state; the rest is deliberately ignored.
  assign unused_s  = ^{rd_pc, upd_pc};

  // Same-cycle lookup from the IF-stage PC; reads pre-update table contents.
  always_comb begin
    hit         = rd_en & valid_r[rd_idx_s] & (tag_r[rd_idx_s] == rd_tag_s);
    pred_taken  = hit & ctr_r[rd_idx_s][1];
    pred_target = rd_pc + 32'd4;
    if (pred_taken) begin
      pred_target = target_r[rd_idx_s];
    end else begin
      pred_target = rd_pc + 32'd4;
    end
  end

  // Mispredict detection and corrected fetch address for the resolved branch.
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = upd_pc + 32'd4;
    if (upd_valid) begin
      mispredict = (upd_taken != upd_pred_taken) |
                   (upd_taken & upd_pred_taken & (upd_target != upd_pred_target));
    end else begin
      mispredict = 1'b0;
    end
    if (upd_taken) begin
      redirect_pc = upd_target;
    end else begin
      redirect_pc = upd_pc + 32'd4;
    end
  end

  // Table training: counters move on hits, taken misses allocate/replace the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_BITS{1'b0}};
        target_r[i] <= 32'd0;
        ctr_r[i]    <= CTR_INIT;
      end
    end else if (upd_valid) begin
      if (upd_hit_s) begin
        if (upd_taken) begin
          ctr_r[upd_idx_s]    <= ctr_inc(ctr_r[upd_idx_s]);
          target_r[upd_idx_s] <= upd_target;
        end else begin
          ctr_r[upd_idx_s]    <= ctr_dec(ctr_r[upd_idx_s]);
        end
      end else if (upd_taken) begin
        valid_r[upd_idx_s]  <= 1'b1;
        tag_r[upd_idx_s]    <= upd_tag_s;
        target_r[upd_idx_s] <= upd_target;
        ctr_r[upd_idx_s]    <= 2'b10;
      end else begin
        valid_r[upd_idx_s]  <= valid_r[upd_idx_s];
      end
    end else begin
      valid_r[upd_idx_s] <= valid_r[upd_idx_s];
    end
  end

  // Saturating debug statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_cnt  <= {CNT_W{1'b0}};
      mispred_cnt <= {CNT_W{1'b0}};
    end else begin
      if (rd_en) begin
        lookup_cnt <= sat_inc(lookup_cnt);
      end else begin
        lookup_cnt <= lookup_cnt;
      end
      if (mispredict) begin
        mispred_cnt <= sat_inc(mispred_cnt);
      end else begin
        mispred_cnt <= mispred_cnt;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Randomized and directed bench for branch_target_buffer against a table-level reference model.
module tb_branch_target_buffer;
  localparam int E = 16;

  logic        clk = 1'b0;
  logic        rst, rd_en, upd_valid, upd_taken, upd_pred_taken;
  logic [31:0] rd_pc, upd_pc, upd_target, upd_pred_target;
  logic        hit, pred_taken, mispredict;
  logic [31:0] pred_target, redirect_pc;
  logic [15:0] lookup_cnt, mispred_cnt;
  logic        unused_hit2, unused_pt2, unused_mis2;
  logic [31:0] unused_ptg2, unused_rdr2;
  logic [1:0]  sat_lookup_cnt, sat_mispred_cnt;

  int checks = 0;
  int errors = 0;

  bit          m_valid  [E];
  int unsigned m_tag    [E];
  logic [31:0] m_target [E];
  int          m_ctr    [E];
  longint      m_lookups, m_mispreds;

  always #5 clk = ~clk;

  branch_target_buffer dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_pc(rd_pc), .hit(hit),
    .pred_taken(pred_taken), .pred_target(pred_target), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .lookup_cnt(lookup_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_target_buffer #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_pc(rd_pc), .hit(unused_hit2),
    .pred_taken(unused_pt2), .pred_target(unused_ptg2), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(unused_mis2), .redirect_pc(unused_rdr2),
    .lookup_cnt(sat_lookup_cnt), .mispred_cnt(sat_mispred_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % E);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc >> 6) % 256;
  endfunction

  function automatic bit m_present(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic logic [31:0] sat_val(input longint n, input longint maxv);
    return (n > maxv) ? 32'(maxv) : 32'(n);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < E; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = 32'd0; m_ctr[i] = 1;
    end
    m_lookups = 0; m_mispreds = 0;
  endtask

  task automatic cycle(input logic r, input logic re, input logic [31:0] rp,
                       input logic uv, input logic [31:0] up, input logic ut,
                       input logic [31:0] utg, input logic upt, input logic [31:0] uptg);
    bit e_hit, e_pt, e_mis;
    logic [31:0] e_tg;
    int ui;
    rst = r; rd_en = re; rd_pc = rp; upd_valid = uv; upd_pc = up; upd_taken = ut;
    upd_target = utg; upd_pred_taken = upt; upd_pred_target = uptg;
    #1;
    e_hit = re && m_present(rp);
    e_pt  = e_hit && (m_ctr[idx_of(rp)] >= 2);
    e_tg  = e_pt ? m_target[idx_of(rp)] : rp + 32'd4;
    e_mis = uv && ((ut != upt) || (ut && upt && utg != uptg));
    check("hit", {31'd0, hit}, {31'd0, e_hit});
    check("pred_taken", {31'd0, pred_taken}, {31'd0, e_pt});
    check("pred_target", pred_target, e_tg);
    check("mispredict", {31'd0, mispredict}, {31'd0, e_mis});
    if (e_mis) check("redirect_pc", redirect_pc, ut ? utg : up + 32'd4);
    check("lookup_cnt", {16'd0, lookup_cnt}, sat_val(m_lookups, 65535));
    check("mispred_cnt", {16'd0, mispred_cnt}, sat_val(m_mispreds, 65535));
    check("sat_lookup_cnt", {30'd0, sat_lookup_cnt}, sat_val(m_lookups, 3));
    check("sat_mispred_cnt", {30'd0, sat_mispred_cnt}, sat_val(m_mispreds, 3));
    @(posedge clk);
    if (r) begin
      m_reset();
    end else begin
      if (re) m_lookups++;
      if (e_mis) m_mispreds++;
      if (uv) begin
        ui = idx_of(up);
        if (m_present(up)) begin
          if (ut) begin
            if (m_ctr[ui] < 3) m_ctr[ui]++;
            m_target[ui] = utg;
          end else if (m_ctr[ui] > 0) begin
            m_ctr[ui]--;
          end
        end else if (ut) begin
          m_valid[ui] = 1'b1; m_tag[ui] = tag_of(up); m_target[ui] = utg; m_ctr[ui] = 2;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic probe(input string t, input logic [31:0] pc, input logic e_hit,
                       input logic [31:0] e_tg);
    rst = 1'b0; rd_en = 1'b1; rd_pc = pc; upd_valid = 1'b0;
    #1;
    check({t, "_hit"}, {31'd0, hit}, {31'd0, e_hit});
    check({t, "_target"}, pred_target, e_tg);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = $urandom & 32'hFFFF_C000;
    p[13:6] = 8'($urandom_range(0, 2));
    p[5:2]  = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 49) == 0) p = 32'hFFFF_FFFC;
    return p;
  endfunction

  initial begin
    logic [31:0] rp, up, utg, uptg;
    logic ut, upt;
    m_reset();
    rst = 1'b1; rd_en = 1'b0; rd_pc = 32'd0; upd_valid = 1'b0; upd_pc = 32'd0;
    upd_taken = 1'b0; upd_target = 32'd0; upd_pred_taken = 1'b0; upd_pred_target = 32'd0;
    @(negedge clk);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    // Lookup on empty table after reset.
    probe("t1_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
    cycle(0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    check("t1_lookup_cnt", {16'd0, lookup_cnt}, 32'd1);
    // Allocation on a taken miss.
    cycle(0, 1, 32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104);
    probe("t2", 32'h100, 1'b1, 32'h200);
    // Not-taken decay to saturation at zero.
    cycle(0, 0, 0, 1, 32'h100, 0, 0, 1, 32'h200);
    probe("t3a", 32'h100, 1'b1, 32'h104);
    for (int i = 0; i < 3; i++) cycle(0, 1, 32'h100, 1, 32'h100, 0, 0, 0, 32'h104);
    probe("t3b", 32'h100, 1'b1, 32'h104);
    cycle(0, 0, 0, 1, 32'h100, 1, 32'h200, 0, 32'h104);
    probe("t3c", 32'h100, 1'b0 | 1'b1, 32'h104);
    cycle(0, 0, 0, 1, 32'h100, 1, 32'h200, 0, 32'h104);
    probe("t3d", 32'h100, 1'b1, 32'h200);
    // Wrong target on a correctly predicted taken branch.
    cycle(0, 1, 32'h100, 1, 32'h100, 1, 32'h300, 1, 32'h200);
    probe("t4", 32'h100, 1'b1, 32'h300);
    // Aliasing index replaces the entry; same-cycle lookup sees old contents.
    cycle(0, 0, 0, 1, 32'h100 + E * 4, 1, 32'h500, 0, 32'h144);
    probe("t5a", 32'h100, 1'b0, 32'h104);
    cycle(0, 1, 32'h140, 1, 32'h140, 0, 0, 1, 32'h500);
    probe("t5b", 32'h140, 1'b1, 32'h144);
    // Statistic saturation at CNT_W=2, then reset racing an update.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 32'h180, 1, 32'h700, 0, 32'h184);
    check("t6_sat_mispred", {30'd0, sat_mispred_cnt}, 32'd3);
    check("t6_mispred", {16'd0, mispred_cnt}, 32'd5);
    cycle(1, 0, 0, 1, 32'h1C0, 1, 32'h700, 0, 32'h1C4);
    probe("t6_rst", 32'h1C0, 1'b0, 32'h1C4);
    check("t6_rst_mispred", {16'd0, mispred_cnt}, 32'd0);
    check("t6_rst_lookup", {16'd0, lookup_cnt}, 32'd0);
    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rp = rand_pc();
      up = rand_pc();
      ut = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: utg = 32'h200;
        1: utg = 32'h300;
        default: utg = rand_pc();
      endcase
      if ($urandom_range(0, 1) == 1) begin
        upt  = m_present(up) && (m_ctr[idx_of(up)] >= 2);
        uptg = upt ? m_target[idx_of(up)] : up + 32'd4;
      end else begin
        upt  = 1'($urandom_range(0, 1));
        uptg = upt ? utg ^ (32'($urandom_range(0, 1)) << 4) : up + 32'd4;
      end
      cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0), rp,
            1'($urandom_range(0, 2) != 0), up, ut, utg, upt, uptg);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
